// File: rtl/serial_add_pkg.sv
// Shared types and constants for the digit-serial adder controller.
package serial_add_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/rca_4b.sv
// 4-bit ripple-carry adder: s + 16*co = a + b + ci.
module rca_4b (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);

   logic [4:0] c_s;

   // Bit-by-bit full-adder ripple.
   always_comb begin
      s      = 4'd0;
      c_s    = 5'd0;
      c_s[0] = ci;
      for (int i = 0; i < 4; i++) begin
         s[i]     = a[i] ^ b[i] ^ c_s[i];
         c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
      end
      co = c_s[4];
   end

endmodule

// File: rtl/serial_add16_ctrl.sv
// Digit-serial adder: one 4-bit digit per clock through a shared rca_4b.
// Optional macro SERIAL_ADD_SUB_EN adds a 'sub' port selecting a + ~b + 1.
module serial_add16_ctrl
   import serial_add_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [NIBBLE_W*NIBBLES-1:0] a,
   input  logic [NIBBLE_W*NIBBLES-1:0] b,
   input  logic                        c_in,
`ifdef SERIAL_ADD_SUB_EN
   input  logic                        sub,
`endif
   output logic                        busy,
   output logic                        done,
   output logic [NIBBLE_W*NIBBLES-1:0] sum,
   output logic                        c_out
);

   localparam int W     = NIBBLE_W * NIBBLES;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   state_e               state_r;
   state_e               state_nx_s;
   logic [IDX_W-1:0]     idx_r;
   logic [W-1:0]         a_r;
   logic [W-1:0]         b_r;
   logic [W-1:0]         sum_r;
   logic                 carry_r;
   logic                 c_out_r;
   logic                 busy_r;
   logic                 done_r;
   logic                 accept_s;
   logic                 last_s;
   logic [W-1:0]         b_eff_s;
   logic                 c_eff_s;
   logic [NIBBLE_W-1:0]  dig_a_s;
   logic [NIBBLE_W-1:0]  dig_b_s;
   logic [NIBBLE_W-1:0]  dig_s_s;
   logic                 dig_co_s;

   // Subtraction is folded into the captured operand: a + ~b + 1.
   always_comb begin
      b_eff_s = b;
      c_eff_s = c_in;
`ifdef SERIAL_ADD_SUB_EN
      if (sub) begin
         b_eff_s = ~b;
         c_eff_s = 1'b1;
      end else begin
         b_eff_s = b;
         c_eff_s = c_in;
      end
`endif
   end

   assign dig_a_s = a_r[idx_r*NIBBLE_W +: NIBBLE_W];
   assign dig_b_s = b_r[idx_r*NIBBLE_W +: NIBBLE_W];

   rca_4b u_rca (
      .a  (dig_a_s),
      .b  (dig_b_s),
      .ci (carry_r),
      .s  (dig_s_s),
      .co (dig_co_s)
   );

   // Next-state and accept/last-digit decode.
   always_comb begin
      state_nx_s = state_r;
      accept_s   = 1'b0;
      last_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_nx_s = RUN;
               accept_s   = 1'b1;
            end else begin
               state_nx_s = IDLE;
            end
         end
         RUN: begin
            if (idx_r == LAST_IDX) begin
               state_nx_s = DONE;
               last_s     = 1'b1;
            end else begin
               state_nx_s = RUN;
            end
         end
         DONE: begin
            if (start) begin
               state_nx_s = RUN;
               accept_s   = 1'b1;
            end else begin
               state_nx_s = IDLE;
            end
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Operand capture, digit accumulation and registered status flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r     <= '0;
         b_r     <= '0;
         sum_r   <= '0;
         idx_r   <= '0;
         carry_r <= 1'b0;
         c_out_r <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         busy_r <= (state_nx_s == RUN);
         done_r <= (state_nx_s == DONE);
         if (accept_s) begin
            a_r     <= a;
            b_r     <= b_eff_s;
            carry_r <= c_eff_s;
            idx_r   <= '0;
            sum_r   <= '0;
            c_out_r <= 1'b0;
         end else if (state_r == RUN) begin
            sum_r[idx_r*NIBBLE_W +: NIBBLE_W] <= dig_s_s;
            carry_r <= dig_co_s;
            idx_r   <= idx_r + IDX_W'(1);
            if (last_s) begin
               c_out_r <= dig_co_s;
            end else begin
               c_out_r <= c_out_r;
            end
         end else begin
            carry_r <= carry_r;
         end
      end
   end

   assign busy  = busy_r;
   assign done  = done_r;
   assign sum   = sum_r;
   assign c_out = c_out_r;

endmodule

// File: tb/tb_serial_add16_ctrl.sv
// Self-checking bench: latency/arithmetic model plus directed and random operations.
module tb_serial_add16_ctrl;

   localparam int NIB = 4;
   localparam int W   = 16;

   logic         clk   = 1'b0;
   logic         rst   = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         c_in  = 1'b0;
   logic         sub   = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         c_out;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   serial_add16_ctrl #(.NIBBLES(NIB)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .c_in  (c_in),
`ifdef SERIAL_ADD_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .c_out (c_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: an accepted op finishes NIB edges later with the arithmetic sum.
   logic         m_busy = 1'b0;
   logic         m_done = 1'b0;
   logic [W-1:0] m_sum  = '0;
   logic         m_cout = 1'b0;
   logic [W:0]   m_pend = '0;
   int           m_cnt  = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_sum  <= '0;
         m_cout <= 1'b0;
         m_pend <= '0;
         m_cnt  <= 0;
      end else if (m_busy) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1) begin
            m_busy           <= 1'b0;
            m_done           <= 1'b1;
            {m_cout, m_sum}  <= m_pend;
         end
      end else if (start) begin
         if (sub)
            m_pend <= (W+1)'({1'b0, a} + {1'b0, ~b} + 17'd1);
         else
            m_pend <= (W+1)'({1'b0, a} + {1'b0, b} + {16'd0, c_in});
         m_cnt  <= NIB;
         m_busy <= 1'b1;
         m_done <= 1'b0;
         m_sum  <= '0;
         m_cout <= 1'b0;
      end else begin
         m_done <= 1'b0;
      end
   end

   // Per-cycle comparison of DUT against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("model_busy", {16'd0, busy}, {16'd0, m_busy});
         check("model_done", {16'd0, done}, {16'd0, m_done});
         if (!m_busy) begin
            check("model_sum", {c_out, sum}, {m_cout, m_sum});
         end
      end
   end

   task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic, input logic is);
      @(posedge clk); #1;
      a = ia; b = ib; c_in = ic; sub = is; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Negedges after the accept edge until done is seen, with busy count.
   task automatic wait_done(output int cyc, output int nbusy);
      bit ok = 1'b0;
      cyc = 0; nbusy = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         cyc++;
         if (done) begin
            ok = 1'b1;
            break;
         end
         if (busy) nbusy++;
      end
      if (!ok) check("done_timeout", 17'd0, 17'd1);
   endtask

   initial begin
      int cyc, nb, dcnt;
      logic [W-1:0] ra, rb;
      logic         rc;
      logic [W:0]   rexp;

      #2;
      check("rst_busy", {16'd0, busy}, 17'd0);
      check("rst_done", {16'd0, done}, 17'd0);
      check("rst_sum",  {c_out, sum},  17'd0);
      #10 rst = 1'b0;
      chk_en = 1'b1;

      issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      wait_done(cyc, nb);
      check("ffff_sum", {c_out, sum}, 17'h10000);
      check("ffff_lat", 17'(cyc - 1), 17'(NIB));

      issue(16'h1234, 16'h4321, 1'b1, 1'b0);
      wait_done(cyc, nb);
      check("1234_sum", {c_out, sum}, 17'h05556);
      check("1234_busy_cycles", 17'(nb), 17'd4);
      @(negedge clk);
      check("1234_done_once", {16'd0, done}, 17'd0);

      issue(16'h1111, 16'h2222, 1'b0, 1'b0);
      @(posedge clk); #1;
      a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(cyc, nb);
      check("ignore_start_sum", {c_out, sum}, 17'h03333);

      issue(16'h0F0F, 16'h0101, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_busy", {16'd0, busy}, 17'd0);
      check("midrst_done", {16'd0, done}, 17'd0);
      check("midrst_sum",  {c_out, sum},  17'd0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      dcnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      check("midrst_no_done", 17'(dcnt), 17'd0);

      @(posedge clk); #1;
      a = 16'h00FF; b = 16'h0F01; c_in = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      wait_done(cyc, nb);
      check("b2b_first", {c_out, sum}, 17'h01000);
      #1;
      a = 16'h8000; b = 16'h8000;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("b2b_no_idle", {16'd0, busy}, 17'd1);
      wait_done(cyc, nb);
      check("b2b_second", {c_out, sum}, 17'h10000);
      #1;
      a = 16'hABCD; b = 16'h1357; c_in = 1'b1;
      @(negedge clk);
      check("hold_after_done", {c_out, sum}, 17'h10000);

`ifdef SERIAL_ADD_SUB_EN
      issue(16'h0005, 16'h0007, 1'b1, 1'b1);
      wait_done(cyc, nb);
      check("sub_5_7", {c_out, sum}, 17'h0FFFE);
      sub = 1'b0;
`endif

      for (int n = 0; n < 1000; n++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom_range(0, 1));
         rexp = (W+1)'({1'b0, ra} + {1'b0, rb} + {16'd0, rc});
         issue(ra, rb, rc, 1'b0);
         wait_done(cyc, nb);
         checks++;
         if ({c_out, sum} !== rexp) begin
            errors++;
            $display("ERRORCHECK FAIL random %h+%h+%b: got %h expected %h", ra, rb, rc, {c_out, sum}, rexp);
         end
      end

      @(negedge clk);
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/serial_add16_ctrl.md
SERIAL_ADD16_CTRL -- requirements
Module: serial_add16_ctrl

Interface
REQ-001 SHALL have parameter NIBBLES, default 4: the number of 4-bit digits per operand; operand width W = 4*NIBBLES.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request to begin an addition; sampled only when busy=0.
REQ-005 SHALL have ports a and b, input, W bits each: the operands, captured on the accepting edge.
REQ-006 SHALL have port c_in, input, 1 bit: carry-in, captured on the accepting edge.
REQ-007 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-008 SHALL have port done, output, 1 bit: a one-cycle pulse marking sum and c_out valid.
REQ-009 SHALL have port sum, output, W bits: the result, held until the next accepted start.
REQ-010 SHALL have port c_out, output, 1 bit: the final carry, held together with sum.

Function
REQ-011 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-012 SHALL accept a request when start=1 in IDLE or DONE: it latches a, b and c_in, clears the digit index, loads the carry register with c_in, clears sum, and enters RUN.
REQ-013 In RUN, SHALL add digit[idx] of A, digit[idx] of B and the carry register with one shared 4-bit adder on each edge.
  - The 4-bit result is written into sum[4*idx+3:4*idx].
  - The carry register takes the adder's carry-out.
  - idx increments.
REQ-014 SHALL leave RUN for DONE on the edge that processes idx=NIBBLES-1; c_out takes the final carry on that same edge.
REQ-015 SHALL drive done=1 for exactly the one cycle spent in DONE; the state then returns to IDLE unless start=1.
REQ-016 Latency: with start accepted at edge 0, done SHALL be high in the cycle after edge NIBBLES (4 for the default).
REQ-017 SHALL assert busy in RUN only; busy SHALL be 0 in IDLE and DONE.
REQ-018 SHALL ignore start while busy=1 (no restart, no operand recapture).
REQ-019 Result arithmetic: {c_out,sum} SHALL equal a+b+c_in modulo 2^(W+1).
REQ-020 SHALL keep sum and c_out stable from done until the next accepted start, even if the a, b and c_in inputs change.
REQ-021 SHALL provide back-to-back operation: start=1 while done=1 begins the new operation with no idle cycle in between.

Reset
REQ-022 rst=1 SHALL immediately force IDLE, idx=0, carry=0, busy=0, done=0, sum=0 and c_out=0, independent of clk.
REQ-023 SHALL abandon any in-flight operation on reset; after rst falls, no done pulse is produced until a new start is accepted.

Configuration
REQ-024 Macro SERIAL_ADD_SUB_EN:
  - When it is defined, the block SHALL add input port sub (1 bit, captured with the operands).
  - With sub=1, the block SHALL compute a + ~b + 1, with the captured c_in ignored and c_out meaning "no borrow".
  - When the macro is undefined, the sub port SHALL be absent and the block SHALL only add.

Structure
REQ-025 The state encoding (IDLE/RUN/DONE) and the NIBBLE_W=4 constant SHALL live in the shared package serial_add_pkg.
REQ-026 The 4-bit adder SHALL be a single instance of the team's existing rca_4b sub-module; the controller SHALL contain no other adder logic.

Verification
REQ-027 The bench SHALL cover: a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1, done exactly 4 cycles after the start edge.
REQ-028 The bench SHALL cover: a=0x1234, b=0x4321, c_in=1 -> sum=0x5556, c_out=0; busy high for 4 cycles, done high for 1 cycle.
REQ-029 The bench SHALL cover: start pulsed during cycle 2 of RUN, with new operands applied -> ignored; the result is still that of the first operands.
REQ-030 The bench SHALL cover: rst asserted mid-RUN between clock edges -> outputs go to zero at once; no done pulse follows until the next start.
REQ-031 The bench SHALL cover: start held high through done -> a second operation starts in the done cycle; results for 0x00FF+0x0F01 and then 0x8000+0x8000 are 0x1000/0 and 0x0000/1.
REQ-032 The bench SHALL cover, with SERIAL_ADD_SUB_EN defined: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, c_out=0.
REQ-033 The bench SHALL also run 1000 random operations checked against a+b+c_in, reporting errors with the "ERRORCHECK" prefix.
